// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits WAIT_CYC
// cycles, accesses the owned RAM and returns the result over rsp_*.
module data_mem_responder #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 256,
   parameter int WAIT_CYC = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [7:0] WAIT_L = 8'(WAIT_CYC);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic req_ready_q, req_ready_d;
   logic rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic rsp_err_q, rsp_err_d;

   logic [DATA_W-1:0] mem [DEPTH];
   logic in_range;
   logic accept;
   logic access;
   logic mem_we;
   logic [IDX_W-1:0] idx;

   assign in_range = ({1'b0, addr_q} < DEPTH_L);
   assign idx      = addr_q[IDX_W-1:0];
   assign accept   = req_valid && req_ready_q;
   assign access   = (state_q == BUSY) && (cnt_q == 8'd0);
   assign mem_we   = access && we_q && in_range;

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

   // State and output registers; RAM is kept out of reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // RAM write port, committed on the access edge of an in-range store
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[idx] <= wdata_q;
      end
   end

   // Next-state logic: IDLE -> BUSY -> RESP -> IDLE
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (accept) state_d = BUSY;
         BUSY: if (cnt_q == 8'd0) state_d = RESP;
         RESP: if (rsp_valid_q && rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and output updates for each state
   always_comb begin
      cnt_d       = cnt_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      unique case (state_q)
         IDLE: begin
            req_ready_d = !accept;
            if (accept) begin
               we_d    = req_we;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               cnt_d   = WAIT_L;
            end
         end
         BUSY: begin
            req_ready_d = 1'b0;
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else begin
               rsp_valid_d = 1'b1;
               if (!in_range) begin
                  rsp_rdata_d = '0;
                  rsp_err_d   = 1'b1;
               end else if (we_q) begin
                  rsp_rdata_d = wdata_q;
                  rsp_err_d   = 1'b0;
               end else begin
                  rsp_rdata_d = mem[idx];
                  rsp_err_d   = 1'b0;
               end
            end
         end
         RESP: begin
            if (rsp_valid_q && rsp_ready) begin
               rsp_valid_d = 1'b0;
               rsp_err_d   = 1'b0;
               req_ready_d = 1'b1;
            end
         end
         default: begin
            req_ready_d = 1'b0;
         end
      endcase
   end

endmodule
